// File: rtl/mem_ctrl_pkg.sv
//==============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared types and constants for the mem_ctrl host-to-SRAM bridge.
//            Optional feature macro: MEM_CTRL_WRITE_VERIFY_EN (adds VRD/VCAP).
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_ctrl_pkg;

    typedef logic [4:0] addr_t;
    typedef logic [7:0] data_t;

    // Saturation ceiling of the write-verify mismatch counter.
    localparam data_t ERR_CNT_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4
`ifdef MEM_CTRL_WRITE_VERIFY_EN
        ,
        VRD  = 3'd5,
        VCAP = 3'd6
`endif
    } ctrl_state_e;

endpackage : mem_ctrl_pkg

`default_nettype wire

// File: rtl/mem_ctrl_if.sv
//==============================================================================
// Module   : mem_ctrl_if
// Brief    : Host request/response channel and downstream memory bus bundled
//            together. slave = controller view, master = host + memory view.
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mem_ctrl_if
    import mem_ctrl_pkg::*;
();

    // Host request channel
    logic  req_valid;
    logic  req_ready;
    logic  req_write;
    addr_t req_addr;
    data_t req_wdata;

    // Host response channel
    logic  rsp_valid;
    logic  rsp_ready;
    data_t rsp_rdata;

    // Downstream synchronous memory
    logic  mem_read;
    logic  mem_write;
    addr_t mem_addr;
    data_t mem_wdata;
    data_t mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface : mem_ctrl_if

`default_nettype wire

// File: rtl/mem_ctrl.sv
//==============================================================================
// Module   : mem_ctrl
// Brief    : Single-outstanding request controller in front of an 8x32
//            synchronous memory. Read latency 2 cycles, response held until
//            the host takes it. All outputs are registered from next-state.
//            Optional feature macro: MEM_CTRL_WRITE_VERIFY_EN -- every write
//            is read back (VRD/VCAP) and mismatches pulse vfy_err and bump
//            a saturating err_cnt.
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_,
    mem_ctrl_if.slave bus
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    ,
    output logic      vfy_err,
    output data_t     err_cnt
`endif
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_n;

    logic  r_req_ready;
    logic  r_rsp_valid;
    data_t r_rsp_rdata;
    logic  r_mem_read;
    logic  r_mem_write;
    addr_t r_mem_addr;
    data_t r_mem_wdata;
    logic  w_accept;

    // req_ready is only ever high while IDLE, so this is the accept condition.
    assign w_accept = bus.req_valid && r_req_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state decode; request inputs only matter in IDLE.
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_n = bus.req_write ? WR : RD;
                end
            end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            WR:   w_state_n = VRD;
            VRD:  w_state_n = VCAP;
            VCAP: w_state_n = IDLE;
`else
            WR:   w_state_n = IDLE;
`endif
            RD:   w_state_n = CAP;
            CAP:  w_state_n = RSP;
            RSP: begin
                // rsp_valid is high throughout RSP, so rsp_ready alone completes it.
                if (bus.rsp_ready) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_req_ready <= (w_state_n == IDLE);
            r_rsp_valid <= (w_state_n == RSP);
            r_mem_write <= (w_state_n == WR);
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            r_mem_read  <= (w_state_n == RD) || (w_state_n == VRD);
`else
            r_mem_read  <= (w_state_n == RD);
`endif
            // Address/data buses hold until the next accepted request; the
            // write data doubles as the reference for the readback compare.
            if (w_accept) begin
                r_mem_addr  <= bus.req_addr;
                r_mem_wdata <= bus.req_wdata;
            end
            // Memory data is valid during CAP, one cycle after the read strobe.
            if (r_state == CAP) begin
                r_rsp_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_CTRL_WRITE_VERIFY_EN
    logic  r_vfy_err;
    data_t r_err_cnt;

    // Readback compare at the end of VCAP; one-cycle error pulse, saturating count.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_vfy_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_vfy_err <= 1'b0;
            if ((r_state == VCAP) && (bus.mem_rdata != r_mem_wdata)) begin
                r_vfy_err <= 1'b1;
                if (r_err_cnt != ERR_CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign vfy_err = r_vfy_err;
    assign err_cnt = r_err_cnt;
`endif

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule : mem_ctrl

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
//==============================================================================
// Module   : tb_mem_ctrl
// Brief    : Scoreboard bench for mem_ctrl with an 8x32 memory model, random
//            response back-pressure and random traffic against a reference
//            memory array. Honours MEM_CTRL_WRITE_VERIFY_EN.
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int c_PERIOD  = 10;
    localparam int c_LATENCY = 2 * c_PERIOD + c_PERIOD / 2;   // accept edge -> first negedge with rsp_valid
    localparam int c_TIMEOUT = 64;

    typedef struct {
        addr_t addr;
        data_t data;
        time   t_acc;
    } exp_t;

    logic  clk;
    logic  rst_;
    mem_ctrl_if bus ();

`ifdef MEM_CTRL_WRITE_VERIFY_EN
    logic  vfy_err;
    data_t err_cnt;
    mem_ctrl dut (.clk(clk), .rst_(rst_), .bus(bus.slave), .vfy_err(vfy_err), .err_cnt(err_cnt));
`else
    mem_ctrl dut (.clk(clk), .rst_(rst_), .bus(bus.slave));
`endif

    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    data_t ref_mem [32];
    data_t sim_mem [32];
    logic  stall   = 1'b0;
    logic  corrupt = 1'b0;
    int    ref_err = 0;
    int    ref_pulses = 0;
    int    seen_pulses = 0;

    initial begin
        clk = 1'b0;
        forever #(c_PERIOD / 2) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream synchronous memory: read data appears the cycle after the strobe.
    // While corrupt is set, read data is flipped so the readback compare misses.
    always @(posedge clk) begin
        if (bus.mem_write) sim_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= sim_mem[bus.mem_addr] ^ (corrupt ? 8'h5A : 8'h00);
    end

    // Host response back-pressure, changed away from both clock edges.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: protocol rules each cycle, scoreboard pop on response handshake.
    logic  prev_rd = 1'b0, prev_wr = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_vfy = 1'b0;
    data_t prev_data = '0;
    always @(negedge clk) begin
        if (rst_) begin
            chk("strobe_exclusive", {31'd0, bus.mem_read && bus.mem_write}, 32'd0);
            if (bus.mem_write) chk("mem_write_width", {31'd0, prev_wr}, 32'd0);
            if (bus.mem_read)  chk("mem_read_width",  {31'd0, prev_rd}, 32'd0);
            if (bus.rsp_valid) begin
                chk("req_ready_in_rsp", {31'd0, bus.req_ready}, 32'd0);
                if (prev_valid && !prev_ready) begin
                    chk("rsp_rdata_stable", {24'd0, bus.rsp_rdata}, {24'd0, prev_data});
                end else if (q.size() == 0) begin
                    chk("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    chk("read_latency", 32'($time - q[0].t_acc), 32'(c_LATENCY));
                end
                if (bus.rsp_ready && q.size() != 0) begin
                    chk($sformatf("rsp_data_a%0d", q[0].addr), {24'd0, bus.rsp_rdata}, {24'd0, q[0].data});
                    void'(q.pop_front());
                end
            end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            if (vfy_err) begin
                seen_pulses++;
                chk("vfy_err_width", {31'd0, prev_vfy}, 32'd0);
            end
            prev_vfy = vfy_err;
`endif
        end else begin
            prev_vfy = 1'b0;
        end
        prev_rd    = rst_ && bus.mem_read;
        prev_wr    = rst_ && bus.mem_write;
        prev_valid = rst_ && bus.rsp_valid;
        prev_ready = bus.rsp_ready;
        prev_data  = bus.rsp_rdata;
    end

    // Issue one request and return right after the accepting edge.
    task automatic do_req(input logic wr, input addr_t a, input data_t d);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= c_TIMEOUT) begin
            chk("req_accept_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (wr) begin
            ref_mem[a] = d;
            if (corrupt) begin
                ref_pulses++;
                if (ref_err < 255) ref_err++;
            end
        end else begin
            q.push_back('{addr: a, data: ref_mem[a], t_acc: $time});
        end
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = addr_t'($urandom);
        bus.req_wdata = data_t'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= c_TIMEOUT) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_err_cnt();
`ifdef MEM_CTRL_WRITE_VERIFY_EN
        chk("err_cnt", {24'd0, err_cnt}, 32'(ref_err));
`endif
    endtask

    task automatic vfy_write(input addr_t a, input data_t d, input logic bad);
        corrupt = bad;
        do_req(1'b1, a, d);
        wait_idle();
        corrupt = 1'b0;
        chk_err_cnt();
    endtask

    initial begin
        addr_t a;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = '0;
            sim_mem[i] = '0;
        end
        bus.mem_rdata = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_ = 1'b0;

        // Reset values.
        #3;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_mem_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk_err_cnt();
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Write then read back addr 5; check write occupancy.
        do_req(1'b1, 5'd5, 8'hA5);
        @(negedge clk);
        chk("wr_busy", {31'd0, bus.req_ready}, 32'd0);
        chk("wr_strobe_data", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {1'b1, 5'd5, 8'hA5});
        @(negedge clk);
`ifdef MEM_CTRL_WRITE_VERIFY_EN
        chk("vrd_strobe", {30'd0, bus.mem_read, bus.req_ready}, 32'd2);
`else
        chk("wr_done", {31'd0, bus.req_ready}, 32'd1);
`endif
        wait_idle();
        do_req(1'b0, 5'd5, 8'h00);
        wait_drain();

        // Address extremes must not alias.
        do_req(1'b1, 5'd0,  8'h01);
        do_req(1'b1, 5'd31, 8'hFF);
        do_req(1'b0, 5'd0,  8'h00);
        do_req(1'b0, 5'd31, 8'h00);
        wait_drain();

        // Held response under 4 cycles of back-pressure.
        stall = 1'b1;
        do_req(1'b1, 5'd12, 8'h3C);
        do_req(1'b0, 5'd12, 8'h00);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("stall_hold", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd2);
            chk("stall_data", {24'd0, bus.rsp_rdata}, 32'h3C);
            @(negedge clk);
        end
        stall = 1'b0;
        wait_drain();

        // Reset while the read strobe is out: everything drops at once.
        do_req(1'b0, 5'd31, 8'h00);
        chk("pre_rst_mem_read", {31'd0, bus.mem_read}, 32'd1);
        rst_ = 1'b0;
        #1;
        chk("rst_abort_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
        if (q.size() != 0) void'(q.pop_back());
        ref_err = 0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        chk_err_cnt();
        do_req(1'b0, 5'd31, 8'h00);
        wait_drain();

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 5'd0;
                1:       a = 5'd31;
                default: a = addr_t'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) begin
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                vfy_write(a, data_t'($urandom), ($urandom_range(0, 3) == 0));
`else
                do_req(1'b1, a, data_t'($urandom));
`endif
            end else begin
                do_req(1'b0, a, 8'h00);
            end
        end
        wait_drain();

`ifdef MEM_CTRL_WRITE_VERIFY_EN
        // Drive the mismatch counter into saturation.
        for (int i = 0; i < 300; i++) begin
            vfy_write(addr_t'($urandom), data_t'($urandom), 1'b1);
        end
        chk("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
        chk("vfy_err_pulses", 32'(seen_pulses), 32'(ref_pulses));
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_ctrl

`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst_  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req_valid  input  1  host request present.
REQ-004 SHALL have port: req_ready  output  1  controller accepts request this cycle.
REQ-005 SHALL have port: req_write  input  1  1=write, 0=read.
REQ-006 SHALL have port: req_addr  input  5  word address 0..31.
REQ-007 SHALL have port: req_wdata  input  8  write data.
REQ-008 SHALL have port: rsp_valid  output  1  read data available.
REQ-009 SHALL have port: rsp_ready  input  1  host takes response.
REQ-010 SHALL have port: rsp_rdata  output  8  read data.
REQ-011 SHALL have port: mem_read, mem_write  output  1 each  strobes to downstream 8x32 synchronous memory.
REQ-012 SHALL have port: mem_addr  output  5, mem_wdata  output  8, mem_rdata  input  8  memory address/data buses.
REQ-013 SHALL have port (only with MEM_CTRL_WRITE_VERIFY_EN): vfy_err  output  1  readback mismatch pulse; err_cnt  output  8  mismatch count.

Function
REQ-014 SHALL accept a request on a posedge where req_valid && req_ready; req_ready SHALL be 1 only in state IDLE.
REQ-015 SHALL implement states IDLE, WR, RD, CAP, RSP (plus VRD, VCAP under macro), all outputs registered.
REQ-016 On accepted write (edge E0): SHALL enter WR, drive mem_write=1, mem_addr, mem_wdata for exactly one cycle (E0..E1); then IDLE (or VRD under macro).
REQ-017 On accepted read (edge E0): SHALL enter RD, drive mem_read=1 for exactly one cycle (E0..E1); CAP during E1..E2; at E2 capture mem_rdata into rsp_rdata, enter RSP, assert rsp_valid.
REQ-018 Read latency SHALL be 2 cycles from acceptance to rsp_valid.
REQ-019 RSP SHALL hold rsp_valid and rsp_rdata stable until rsp_valid && rsp_ready, then return to IDLE; no new request accepted meanwhile.
REQ-020 mem_read and mem_write SHALL never be 1 simultaneously.
REQ-021 mem_addr and mem_wdata SHALL hold their last values until the next accepted request (memory samples write data 1 ns after the edge).
REQ-022 Addresses 0 and 31 SHALL be handled identically to others; no wrap or range logic.
REQ-023 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-024 rst_ low SHALL immediately force: state IDLE, req_ready=0 while in reset then 1 after release, rsp_valid=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, vfy_err=0, err_cnt=0.
REQ-025 Reset mid-operation SHALL abort the transaction with no response and no strobe continuation.

Configuration
REQ-026 Macro MEM_CTRL_WRITE_VERIFY_EN defined: after WR, SHALL go VRD (mem_read=1 one cycle, same addr), VCAP, compare mem_rdata to stored wdata at the VCAP edge; mismatch pulses vfy_err one cycle and increments err_cnt saturating at 255; then IDLE. Write occupancy 3 cycles.
REQ-027 Macro undefined: no VRD/VCAP, no vfy_err/err_cnt ports; write occupancy 1 cycle.

Structure
REQ-028 Package mem_ctrl_pkg SHALL hold addr_t (5-bit), data_t (8-bit), ctrl_state_e enum, ERR_CNT_MAX=255.
REQ-029 Sub-module SHALL NOT be required; the controller is a single module, instantiated upstream of mem.

Verification
REQ-030 Write addr 5 data 8'hA5, then read addr 5 -> rsp_valid 2 cycles after acceptance, rsp_rdata=8'hA5.
REQ-031 Write addr 0 = 8'h01 and addr 31 = 8'hFF, read both -> 8'h01, 8'hFF; addr 0 not aliased.
REQ-032 Read with rsp_ready=0 for 4 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 until handshake.
REQ-033 Assert rst_ during RD -> mem_read=0 and rsp_valid=0 immediately; after release, next read completes normally.
REQ-034 Every cycle: assert !(mem_read && mem_write); mem_write/mem_read pulse width exactly 1 cycle.
REQ-035 With MEM_CTRL_WRITE_VERIFY_EN, force mem_rdata corruption during VCAP -> vfy_err pulse, err_cnt 0->1; 300 forced errors -> err_cnt=255.
